multi_lock_ctrl: RTL

Parametrised UART lock controller driving `N_LOCKS` independent lock outputs. It is the successor to the single-lock `'A'`/`'C'` controller. It decodes a two-byte command (opcode + ASCII channel digit) from the ESP32 link and adds a single-byte close-all command. Each channel has a retriggerable auto-relock timer, an inter-byte timeout and error/acknowledge pulses. It sits between the board RX pin and the lock driver outputs, reusing the existing `uart_rx`.

---
 rtl/multi_lock_ctrl_pkg.sv | 16 +
 rtl/multi_lock_ctrl_if.sv | 12 +
 rtl/multi_lock_ctrl_relock_timer.sv | 32 +++
 rtl/uart_rx.sv | 77 +++++++
 rtl/multi_lock_ctrl.sv | 123 ++++++++++++
 5 files changed

// File: rtl/multi_lock_ctrl_pkg.sv
// Shared constants, FSM state type and width helper for the multi-channel UART lock controller.
package lock_ctrl_pkg;

  localparam logic [7:0] OP_OPEN      = 8'h41;
  localparam logic [7:0] OP_CLOSE     = 8'h43;
  localparam logic [7:0] OP_ALL_CLOSE = 8'h58;
  localparam logic [7:0] CH_BASE      = 8'h30;

  typedef enum logic {S_CMD, S_CHAN} state_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input longint unsigned max_val);
    return (max_val == 0) ? 1 : int'($clog2(max_val + 1));
  endfunction

endpackage

// File: rtl/multi_lock_ctrl_if.sv
// Board-side signal bundle: ESP32 RX line in, lock drive and status pulses out.
interface multi_lock_ctrl_if #(
  parameter int unsigned N_LOCKS = 4
);
  logic               rx_pin;
  logic [N_LOCKS-1:0] lock_open;
  logic               cmd_ok;
  logic               cmd_err;

  modport master (output rx_pin, input lock_open, cmd_ok, cmd_err);
  modport slave  (input rx_pin, output lock_open, cmd_ok, cmd_err);
endinterface

// File: rtl/multi_lock_ctrl_relock_timer.sv
// Per-channel retriggerable relock countdown; expire is high on the cycle the count is 1.
module lock_relock_timer
  import lock_ctrl_pkg::*;
#(
  parameter int unsigned RELOCK_CYCLES = 250_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic expire
);
  localparam int unsigned TW = cnt_width(RELOCK_CYCLES);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= TW'(RELOCK_CYCLES);
    end else if (r_count != '0) begin
      r_count <= r_count - TW'(1);
    end
  end

  // Combinational so the lock drops on the same edge the count reaches zero.
  assign expire = (r_count == TW'(1));

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples mid-bit, emits a one-cycle o_Rx_DV with the received byte.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       i_Clock,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP} rx_state_t;

  logic          r_Rx_Data_R;
  logic          r_Rx_Data;
  logic [CW-1:0] r_Clk_Count;
  logic [2:0]    r_Bit_Index;
  logic [7:0]    r_Rx_Byte;
  logic          r_Rx_DV;
  rx_state_t     r_SM_Main;

  always_ff @(posedge i_Clock) begin
    r_Rx_Data_R <= i_Rx_Serial;
    r_Rx_Data   <= r_Rx_Data_R;
  end

  always_ff @(posedge i_Clock) begin
    case (r_SM_Main)
      RX_IDLE: begin
        r_Rx_DV     <= 1'b0;
        r_Clk_Count <= '0;
        r_Bit_Index <= '0;
        if (r_Rx_Data == 1'b0) r_SM_Main <= RX_START;
      end
      RX_START: begin
        if (r_Clk_Count == CW'((CLKS_PER_BIT - 1) / 2)) begin
          r_Clk_Count <= '0;
          r_SM_Main   <= (r_Rx_Data == 1'b0) ? RX_DATA : RX_IDLE;
        end else begin
          r_Clk_Count <= r_Clk_Count + CW'(1);
        end
      end
      RX_DATA: begin
        if (r_Clk_Count < CW'(CLKS_PER_BIT - 1)) begin
          r_Clk_Count <= r_Clk_Count + CW'(1);
        end else begin
          r_Clk_Count            <= '0;
          r_Rx_Byte[r_Bit_Index] <= r_Rx_Data;
          if (r_Bit_Index < 3'd7) begin
            r_Bit_Index <= r_Bit_Index + 3'd1;
          end else begin
            r_Bit_Index <= '0;
            r_SM_Main   <= RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (r_Clk_Count < CW'(CLKS_PER_BIT - 1)) begin
          r_Clk_Count <= r_Clk_Count + CW'(1);
        end else begin
          r_Rx_DV     <= 1'b1;
          r_Clk_Count <= '0;
          r_SM_Main   <= RX_CLEANUP;
        end
      end
      RX_CLEANUP: begin
        r_Rx_DV   <= 1'b0;
        r_SM_Main <= RX_IDLE;
      end
      default: r_SM_Main <= RX_IDLE;
    endcase
  end

  assign o_Rx_DV   = r_Rx_DV;
  assign o_Rx_Byte = r_Rx_Byte;

endmodule

// File: rtl/multi_lock_ctrl.sv
// UART command decoder driving N_LOCKS lock outputs: 'A'/'C' + digit, 'X' closes all.
module multi_lock_ctrl
  import lock_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT  = 434,
  parameter int unsigned N_LOCKS       = 4,
  parameter int unsigned RELOCK_CYCLES = 250_000_000,
  parameter int unsigned BYTE_TIMEOUT  = 50_000
) (
  input logic             clk,
  input logic             rst_n,
  multi_lock_ctrl_if.slave bus
);
  localparam int unsigned CW = cnt_width(BYTE_TIMEOUT);

  logic               w_rx_dv;
  logic [7:0]         w_rx_byte;
  logic [7:0]         w_chan;
  logic               w_chan_valid;
  logic               w_all_close;
  logic [CW-1:0]      w_cnt_next;
  logic [N_LOCKS-1:0] w_open;
  logic [N_LOCKS-1:0] w_load;
  logic [N_LOCKS-1:0] w_clear;
  logic [N_LOCKS-1:0] w_expire;
  logic [N_LOCKS-1:0] w_lock_next;

  state_t             r_state;
  logic [7:0]         r_opcode;
  logic [CW-1:0]      r_cnt;
  logic [N_LOCKS-1:0] r_lock_open;
  logic               r_cmd_ok;
  logic               r_cmd_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
    .i_Clock     (clk),
    .i_Rx_Serial (bus.rx_pin),
    .o_Rx_DV     (w_rx_dv),
    .o_Rx_Byte   (w_rx_byte)
  );

  assign w_chan       = w_rx_byte - CH_BASE;
  assign w_chan_valid = w_rx_dv && (r_state == S_CHAN) && (w_rx_byte >= CH_BASE)
                        && (w_rx_byte < CH_BASE + 8'(N_LOCKS));
  assign w_all_close  = w_rx_dv && (r_state == S_CMD) && (w_rx_byte == OP_ALL_CLOSE);
  assign w_cnt_next   = r_cnt + CW'(1);

  // An executing command outranks a same-edge timer expiry on its channel.
  always_comb begin
    w_open      = '0;
    w_load      = '0;
    w_clear     = '0;
    w_lock_next = r_lock_open;
    for (int unsigned k = 0; k < N_LOCKS; k++) begin
      if (w_chan_valid && (w_chan == 8'(k))) begin
        w_open[k]  = (r_opcode == OP_OPEN);
        w_clear[k] = (r_opcode == OP_CLOSE);
      end
      if (w_all_close) w_clear[k] = 1'b1;
      w_load[k] = w_open[k] && (RELOCK_CYCLES != 0);
      if (w_open[k])                     w_lock_next[k] = 1'b1;
      else if (w_clear[k] || w_expire[k]) w_lock_next[k] = 1'b0;
    end
  end

  for (genvar g = 0; g < N_LOCKS; g++) begin : g_timer
    lock_relock_timer #(.RELOCK_CYCLES(RELOCK_CYCLES)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (w_load[g]),
      .clear  (w_clear[g]),
      .expire (w_expire[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_CMD;
      r_opcode    <= '0;
      r_cnt       <= '0;
      r_lock_open <= '0;
      r_cmd_ok    <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_cmd_ok    <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_lock_open <= w_lock_next;
      case (r_state)
        S_CMD: begin
          if (w_rx_dv) begin
            if ((w_rx_byte == OP_OPEN) || (w_rx_byte == OP_CLOSE)) begin
              r_opcode <= w_rx_byte;
              r_cnt    <= '0;
              r_state  <= S_CHAN;
            end else if (w_rx_byte == OP_ALL_CLOSE) begin
              r_cmd_ok <= 1'b1;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
        end
        S_CHAN: begin
          // A byte arriving on the timeout edge is decoded, not timed out.
          if (w_rx_dv) begin
            r_state <= S_CMD;
            if (w_chan_valid) r_cmd_ok  <= 1'b1;
            else              r_cmd_err <= 1'b1;
          end else if (w_cnt_next == CW'(BYTE_TIMEOUT)) begin
            r_cmd_err <= 1'b1;
            r_state   <= S_CMD;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
      endcase
    end
  end

  assign bus.lock_open = r_lock_open;
  assign bus.cmd_ok    = r_cmd_ok;
  assign bus.cmd_err   = r_cmd_err;

endmodule
